// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, link register index, load-type codes.
package cpu_pkg;

  localparam int DW       = 32;
  localparam int AW       = 5;
  localparam int LINK_REG = 31;

  // Load-type encodings carried on mem_ldtype; codes 5-7 decode as a word load.
  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } ldtype_e;

endpackage

// File: rtl/wb_load_ext.sv
// Load extraction/extension (little-endian) and alignment check. Purely combinational.
module wb_load_ext #(
  parameter int DW = 32
) (
  input  logic [2:0]    ldtype,
  input  logic [1:0]    off,
  input  logic [DW-1:0] rdata,
  output logic [DW-1:0] data,
  output logic          misaligned
);
  import cpu_pkg::*;

  logic [7:0]  b;
  logic [15:0] h;

  assign b = 8'(rdata >> {off, 3'b000});
  assign h = 16'(rdata >> {off[1], 4'b0000});

  // Pick and extend the addressed byte/half; anything not byte/half is a word.
  always_comb begin
    data       = rdata;
    misaligned = 1'b0;
    case (ldtype)
      LD_B:  data = {{(DW-8){b[7]}}, b};
      LD_BU: data = {{(DW-8){1'b0}}, b};
      LD_H:  begin data = {{(DW-16){h[15]}}, h}; misaligned = off[0]; end
      LD_HU: begin data = {{(DW-16){1'b0}}, h};  misaligned = off[0]; end
      default: misaligned = (off != 2'b00);
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and register-file write driver with forwarding view.
// Optional feature: define WB_RETIRE_CNT_EN to add the 32-bit retire_cnt output.
module wb_stage #(
  parameter int DW       = cpu_pkg::DW,
  parameter int AW       = cpu_pkg::AW,
  parameter int LINK_REG = cpu_pkg::LINK_REG
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_valid,
  input  logic          mem_regwr,
  input  logic [AW-1:0] mem_rw,
  input  logic [DW-1:0] mem_alu,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_memtoreg,
  input  logic [2:0]    mem_ldtype,
  input  logic          mem_link,
  input  logic [DW-1:0] mem_pc8,
  input  logic          mem_ovf,
  input  logic          wb_stall,
  input  logic          wb_flush,
  output logic          RegWr,
  output logic [AW-1:0] Rw,
  output logic [DW-1:0] Busw,
  output logic          fwd_valid,
  output logic [AW-1:0] fwd_rw,
  output logic [DW-1:0] fwd_data,
  output logic          prev_valid,
  output logic [AW-1:0] prev_rw,
  output logic [DW-1:0] prev_data,
  output logic          exc_ovf,
  output logic          exc_adel
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]   retire_cnt
`endif
);
  import cpu_pkg::*;

  typedef struct packed {
    logic          valid;
    logic          regwr;
    logic          ovf;
    logic          adel;
    logic          link;
    logic          memtoreg;
    logic [AW-1:0] rw;
    logic [DW-1:0] alu;
    logic [DW-1:0] ld;
    logic [DW-1:0] pc8;
  } wb_reg_t;

  wb_reg_t       q;
  logic [DW-1:0] ld_data;
  logic          ld_mis;
  logic          adel_in;
  logic          live_in;

  // Extension runs on the MEM-side word so only the final load value is latched.
  wb_load_ext #(.DW(DW)) u_ld (
    .ldtype     (mem_ldtype),
    .off        (mem_alu[1:0]),
    .rdata      (mem_rdata),
    .data       (ld_data),
    .misaligned (ld_mis)
  );

  assign live_in = mem_valid & ~wb_flush;
  // A link write never touches memory, so alignment is only checked on real loads.
  assign adel_in = mem_memtoreg & ~mem_link & ld_mis;

  // WB register: capture on non-stalled edges; flush always kills the valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= '0;
      exc_ovf  <= 1'b0;
      exc_adel <= 1'b0;
    end else if (wb_stall) begin
      q.valid  <= q.valid & ~wb_flush;
      exc_ovf  <= 1'b0;
      exc_adel <= 1'b0;
    end else begin
      q.valid    <= live_in;
      q.regwr    <= mem_regwr;
      q.ovf      <= mem_ovf;
      q.adel     <= adel_in;
      q.link     <= mem_link;
      q.memtoreg <= mem_memtoreg;
      q.rw       <= mem_link ? AW'(LINK_REG) : mem_rw;
      q.alu      <= mem_alu;
      q.ld       <= ld_data;
      q.pc8      <= mem_pc8;
      exc_ovf    <= live_in & mem_regwr & mem_ovf;
      exc_adel   <= live_in & adel_in;
    end
  end

  assign Rw    = q.rw;
  assign Busw  = q.link ? q.pc8 : (q.memtoreg ? q.ld : q.alu);
  assign RegWr = q.valid & q.regwr & ~q.ovf & ~q.adel & (q.rw != '0);

  assign fwd_valid = RegWr;
  assign fwd_rw    = Rw;
  assign fwd_data  = Busw;

  // Previous-commit copy for bypassing a regfile read that samples before the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
      prev_rw    <= '0;
      prev_data  <= '0;
    end else if (!wb_stall) begin
      prev_valid <= fwd_valid;
      prev_rw    <= fwd_rw;
      prev_data  <= fwd_data;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  // Count instructions leaving WB without an exception, write or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retire_cnt <= '0;
    else if (q.valid & ~wb_stall & ~q.ovf & ~q.adel)
      retire_cnt <= retire_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus a randomized run
// compared against a spec-level instruction model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, mem_regwr, mem_memtoreg, mem_link, mem_ovf;
  logic [4:0]  mem_rw;
  logic [31:0] mem_alu, mem_rdata, mem_pc8;
  logic [2:0]  mem_ldtype;
  logic        wb_stall, wb_flush;
  logic        RegWr, fwd_valid, prev_valid, exc_ovf, exc_adel;
  logic [4:0]  Rw, fwd_rw, prev_rw;
  logic [31:0] Busw, fwd_data, prev_data;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_regwr(mem_regwr), .mem_rw(mem_rw),
    .mem_alu(mem_alu), .mem_rdata(mem_rdata), .mem_memtoreg(mem_memtoreg),
    .mem_ldtype(mem_ldtype), .mem_link(mem_link), .mem_pc8(mem_pc8),
    .mem_ovf(mem_ovf), .wb_stall(wb_stall), .wb_flush(wb_flush),
    .RegWr(RegWr), .Rw(Rw), .Busw(Busw),
    .fwd_valid(fwd_valid), .fwd_rw(fwd_rw), .fwd_data(fwd_data),
    .prev_valid(prev_valid), .prev_rw(prev_rw), .prev_data(prev_data),
    .exc_ovf(exc_ovf), .exc_adel(exc_adel)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  typedef struct {
    bit        valid, regwr, memtoreg, link, ovf;
    bit [2:0]  ldtype;
    bit [4:0]  rw;
    bit [31:0] alu, rdata, pc8;
  } ins_t;

  function automatic ins_t idle();
    ins_t i;
    i.valid = 0; i.regwr = 0; i.memtoreg = 0; i.link = 0; i.ovf = 0;
    i.ldtype = 0; i.rw = 0; i.alu = 0; i.rdata = 0; i.pc8 = 0;
    return i;
  endfunction

  function automatic ins_t alu_wr(input bit [4:0] rw, input bit [31:0] v);
    ins_t i = idle();
    i.valid = 1; i.regwr = 1; i.rw = rw; i.alu = v;
    return i;
  endfunction

  // Spec-level result of one instruction sitting in WB.
  function automatic void model(input ins_t i, output bit we, output bit [4:0] rw,
                                output bit [31:0] d, output bit eo, output bit ea);
    int unsigned off = i.alu % 4;
    int unsigned t   = (i.ldtype > 4) ? 0 : i.ldtype;
    bit [31:0] part;
    bit mis = 0;
    if (i.memtoreg && !i.link) begin
      if (t == 0)               mis = (off != 0);
      else if (t == 3 || t == 4) mis = (off % 2 != 0);
    end
    rw = i.link ? 5'd31 : i.rw;
    if (i.link) d = i.pc8;
    else if (!i.memtoreg) d = i.alu;
    else if (t == 1 || t == 2) begin
      part = (i.rdata >> (8 * off)) % 256;
      d = (t == 1 && part >= 128) ? part + 32'hFFFFFF00 : part;
    end else if (t == 3 || t == 4) begin
      part = (i.rdata >> (16 * (off / 2))) % 65536;
      d = (t == 3 && part >= 32768) ? part + 32'hFFFF0000 : part;
    end else d = i.rdata;
    eo = i.valid && i.regwr && i.ovf;
    ea = i.valid && mis;
    we = i.valid && i.regwr && !i.ovf && !mis && (rw != 0);
  endfunction

  task automatic drive(input ins_t i);
    mem_valid = i.valid; mem_regwr = i.regwr; mem_memtoreg = i.memtoreg;
    mem_link = i.link; mem_ovf = i.ovf; mem_ldtype = i.ldtype; mem_rw = i.rw;
    mem_alu = i.alu; mem_rdata = i.rdata; mem_pc8 = i.pc8;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; wb_stall = 0; wb_flush = 0; drive(idle());
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wb_stall = 0; wb_flush = 0; drive(idle());
    #1;
    n_tests++;
    if ({RegWr, Rw, Busw, fwd_valid, fwd_rw, fwd_data, prev_valid, prev_rw, prev_data,
         exc_ovf, exc_adel} !== '0) begin
      n_fail++; $display("FAIL reset_init: outputs not zero (RegWr=%b Busw=%h)", RegWr, Busw);
    end
    @(negedge clk) rst_n = 1'b1;
    drive(alu_wr(5'd5, 32'h1234)); step();
    n_tests++;
    if (RegWr !== 1'b1 || Rw !== 5'd5 || Busw !== 32'h1234) begin
      n_fail++; $display("FAIL reset_first_wr: got %b/%0d/%h want 1/5/00001234", RegWr, Rw, Busw);
    end
    drive(alu_wr(5'd6, 32'h66)); step();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({RegWr, Rw, Busw, fwd_valid, fwd_rw, fwd_data, prev_valid, prev_rw, prev_data,
         exc_ovf, exc_adel} !== '0) begin
      n_fail++; $display("FAIL reset_async: outputs not zero (RegWr=%b prev_rw=%0d)", RegWr, prev_rw);
    end
    drive(idle());
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_loads();
    bit [2:0]  t_tab[5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    bit [1:0]  o_tab[5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd2};
    bit [31:0] d_tab[5] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01, 32'h0};
    bit        w_tab[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ins_t i;
    for (int k = 0; k < 5; k++) begin
      i = idle();
      i.valid = 1; i.regwr = 1; i.memtoreg = 1; i.rw = 5'd9;
      i.ldtype = t_tab[k]; i.alu = 32'h100 + 32'(o_tab[k]); i.rdata = 32'h80FF7F01;
      drive(i); step();
      n_tests++;
      if (RegWr !== w_tab[k] || (w_tab[k] && Busw !== d_tab[k]) || exc_adel !== !w_tab[k]) begin
        n_fail++;
        $display("FAIL load_%0d: RegWr=%b Busw=%h adel=%b want %b/%h/%b",
                 k, RegWr, Busw, exc_adel, w_tab[k], d_tab[k], !w_tab[k]);
      end
    end
    drive(idle()); step();
    n_tests++;
    if (exc_adel !== 1'b0) begin
      n_fail++; $display("FAIL adel_pulse: exc_adel=%b want 0", exc_adel);
    end
  endtask

  task automatic test_suppress();
    ins_t i = alu_wr(5'd8, 32'h88);
    i.ovf = 1; drive(i); step();
    n_tests++;
    if (RegWr !== 1'b0 || exc_ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_suppress: RegWr=%b exc_ovf=%b want 0/1", RegWr, exc_ovf);
    end
    drive(alu_wr(5'd0, 32'h77)); step();
    n_tests++;
    if (RegWr !== 1'b0 || exc_ovf !== 1'b0 || exc_adel !== 1'b0) begin
      n_fail++; $display("FAIL r0_suppress: RegWr=%b ovf=%b adel=%b want 0/0/0", RegWr, exc_ovf, exc_adel);
    end
  endtask

  task automatic test_link();
    ins_t i = alu_wr(5'd7, 32'hDEAD);
    i.link = 1; i.pc8 = 32'h3008; drive(i); step();
    n_tests++;
    if (RegWr !== 1'b1 || Rw !== 5'd31 || Busw !== 32'h3008) begin
      n_fail++; $display("FAIL link: got %b/%0d/%h want 1/31/00003008", RegWr, Rw, Busw);
    end
    drive(idle());
  endtask

  task automatic test_stall_flush();
    ins_t i;
    drive(alu_wr(5'd3, 32'h11)); step();
    i = alu_wr(5'd8, 32'h88); i.ovf = 1; drive(i); step();
    n_tests++;
    if (exc_ovf !== 1'b1 || prev_rw !== 5'd3) begin
      n_fail++; $display("FAIL stall_setup: exc_ovf=%b prev_rw=%0d want 1/3", exc_ovf, prev_rw);
    end
    wb_stall = 1; drive(alu_wr(5'd12, 32'hCC));
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++;
      if (exc_ovf !== 1'b0 || RegWr !== 1'b0 || Rw !== 5'd8 || prev_valid !== 1'b1 ||
          prev_rw !== 5'd3 || prev_data !== 32'h11) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: ovf=%b RegWr=%b Rw=%0d prev=%b/%0d/%h want 0/0/8 1/3/11",
                 c, exc_ovf, RegWr, Rw, prev_valid, prev_rw, prev_data);
      end
    end
    wb_stall = 0; drive(alu_wr(5'd4, 32'h44)); step();
    wb_stall = 1; wb_flush = 1; drive(idle()); step();
    n_tests++;
    if (RegWr !== 1'b0) begin
      n_fail++; $display("FAIL stall_flush: RegWr=%b want 0", RegWr);
    end
    wb_stall = 0; wb_flush = 0;
  endtask

  task automatic test_back_to_back();
    drive(alu_wr(5'd3, 32'hA)); step();
    drive(alu_wr(5'd4, 32'hB)); step();
    n_tests++;
    if (fwd_valid !== 1'b1 || fwd_rw !== 5'd4 || fwd_data !== 32'hB ||
        prev_valid !== 1'b1 || prev_rw !== 5'd3 || prev_data !== 32'hA) begin
      n_fail++;
      $display("FAIL fwd_b2b: fwd=%b/%0d/%h prev=%b/%0d/%h want 1/4/b 1/3/a",
               fwd_valid, fwd_rw, fwd_data, prev_valid, prev_rw, prev_data);
    end
    drive(idle());
  endtask

  task automatic test_random();
    ins_t cur, n;
    bit we, eo, ea, pv, st, fl, pwe, peo, pea;
    bit [4:0] rw, prw, prw2;
    bit [31:0] d, pd, pd2;
    do_reset();
    cur = idle(); pv = 0; prw = 0; pd = 0;
    for (int c = 0; c < 300; c++) begin
      n = idle();
      n.valid = ($urandom_range(0, 9) != 0); n.regwr = ($urandom_range(0, 6) != 0);
      n.memtoreg = ($urandom_range(0, 4) < 2); n.link = ($urandom_range(0, 9) == 0);
      n.ovf = ($urandom_range(0, 9) == 0); n.ldtype = 3'($urandom_range(0, 7));
      n.rw = 5'($urandom); n.alu = $urandom; n.rdata = $urandom; n.pc8 = $urandom;
      st = ($urandom_range(0, 9) == 0); fl = ($urandom_range(0, 9) == 0);
      drive(n); wb_stall = st; wb_flush = fl;
      step();
      model(cur, pwe, prw2, pd2, peo, pea);
      if (!st) begin
        pv = pwe; prw = prw2; pd = pd2;
        cur = n; cur.valid = n.valid && !fl;
        model(cur, we, rw, d, eo, ea);
      end else begin
        cur.valid = cur.valid && !fl;
        model(cur, we, rw, d, eo, ea);
        eo = 0; ea = 0;
      end
      n_tests++;
      if (RegWr !== we || (we && (Rw !== rw || Busw !== d)) || fwd_valid !== we ||
          (we && (fwd_rw !== rw || fwd_data !== d)) || exc_ovf !== eo || exc_adel !== ea ||
          prev_valid !== pv || (pv && (prev_rw !== prw || prev_data !== pd))) begin
        n_fail++;
        $display("FAIL rand_%0d: RegWr=%b Rw=%0d Busw=%h ovf=%b adel=%b prev=%b/%0d/%h want %b/%0d/%h %b/%b %b/%0d/%h",
                 c, RegWr, Rw, Busw, exc_ovf, exc_adel, prev_valid, prev_rw, prev_data,
                 we, rw, d, eo, ea, pv, prw, pd);
      end
    end
    wb_stall = 0; wb_flush = 0; drive(idle());
  endtask

`ifdef WB_RETIRE_CNT_EN
  task automatic test_retire_cnt();
    ins_t i;
    do_reset();
    drive(alu_wr(5'd1, 32'h1)); step();
    drive(alu_wr(5'd2, 32'h2)); step();
    i = alu_wr(5'd3, 32'h3); i.ovf = 1; drive(i); step();
    drive(alu_wr(5'd4, 32'h4)); wb_stall = 1; step();
    wb_stall = 0; step();
    drive(alu_wr(5'd5, 32'h5)); step();
    drive(idle()); step();
    n_tests++;
    if (retire_cnt !== 32'd4) begin
      n_fail++; $display("FAIL retire_cnt: got %0d want 4", retire_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_loads();
    test_suppress();
    test_link();
    test_stall_flush();
    test_back_to_back();
    test_random();
`ifdef WB_RETIRE_CNT_EN
    test_retire_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register and writeback driver; the producer side of the register-file write port (RegWr/Rw/Busw).
- Latches the retiring instruction from MEM and selects the ALU result, the extended load data, or the link address.
- Suppresses illegal writes and drives the register-file write port one cycle after capture.
- Also publishes a forwarding view (current plus previous commit) for the ID-stage hazard/bypass logic.

Parameters:
- DW, 32, datapath width
- AW, 5, register index width
- LINK_REG, 31, destination index for link (jal) writes

Ports:
- clk  in  1  clock; all state on posedge
- rst_n  in  1  asynchronous active-low reset
- mem_valid  in  1  MEM holds a valid instruction
- mem_regwr  in  1  instruction writes a GPR
- mem_rw  in  AW  destination index (rt|rd)
- mem_alu  in  DW  ALU result / effective address
- mem_rdata  in  DW  raw data-memory word
- mem_memtoreg  in  1  select load path
- mem_ldtype  in  3  0=LW 1=LB 2=LBU 3=LH 4=LHU; 5-7 are treated as LW
- mem_link  in  1  link write of mem_pc8 to LINK_REG
- mem_pc8  in  DW  PC+8
- mem_ovf  in  1  arithmetic overflow
- wb_stall  in  1  hold the WB register
- wb_flush  in  1  squash the captured instruction
- RegWr  out  1  register-file write enable
- Rw  out  AW  register-file write index
- Busw  out  DW  register-file write data
- fwd_valid  out  1  current WB write is live
- fwd_rw  out  AW  current WB destination
- fwd_data  out  DW  current WB data (equals Busw)
- prev_valid  out  1  previous-cycle commit is live
- prev_rw  out  AW  previous-cycle destination
- prev_data  out  DW  previous-cycle data
- exc_ovf  out  1  one-cycle pulse: write suppressed by overflow
- exc_adel  out  1  one-cycle pulse: misaligned load

Behaviour:
- Reset (rst_n low, asynchronous): every output and internal register goes to 0.
- Capture: on posedge with wb_stall=0, latch the MEM fields.
  - Valid bit becomes mem_valid & ~wb_flush.
  - Latency is 1 cycle: the MEM inputs at edge N drive RegWr/Rw/Busw during cycle N+1.
- Stall: wb_stall=1 holds every latched field.
  - exc_* pulses do not repeat while stalled.
  - prev_* does not advance while stalled.
- Flush: wb_flush=1 clears the valid bit at the edge. If stall and flush are asserted together, flush wins and the valid bit clears.
- Data select, in priority order:
  - mem_link: data = mem_pc8, index = LINK_REG.
  - mem_memtoreg: data = extended load data.
  - otherwise: data = mem_alu.
- Load extension (little-endian), with off = mem_alu[1:0]:
  - LB/LBU take byte rdata[8*off+:8], sign- or zero-extended.
  - LH/LHU take half rdata[16*off[1]+:16], sign- or zero-extended.
- Alignment:
  - LH/LHU with off[0]=1, or LW with off!=0, is misaligned.
  - A misaligned load gives a write enable of 0 and exc_adel=1 for one cycle.
- RegWr = valid & regwr & ~ovf & ~adel & (Rw != 0).
  - Overflow suppresses the write and pulses exc_ovf for one cycle.
  - A write to r0 is suppressed without an exception.
- Forwarding:
  - fwd_valid = RegWr, fwd_rw = Rw, fwd_data = Busw.
  - prev_* is a registered copy of fwd_*, updated on every non-stalled edge.
  - prev_* covers the case where a regfile read samples before the write lands.
- Outputs are registered except RegWr/Busw, which are combinational from the latched fields.

Optional Feature:
- WB_RETIRE_CNT_EN defined:
  - Adds output retire_cnt (32 bits, reset 0).
  - Increments by 1 on each edge where valid & ~wb_stall & ~ovf & ~adel, whether or not RegWr is set.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: the port and the counter are absent.

Decomposition:
- Shared package (cpu_pkg): LDTYPE encodings (LD_W/LD_B/LD_BU/LD_H/LD_HU), LINK_REG, DW, AW.
- One sub-module, wb_load_ext: purely combinational; inputs ldtype, off, rdata; outputs data and misaligned.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> all outputs 0 immediately. Release, then feed an ALU write r5=0x1234 -> RegWr=1, Rw=5, Busw=0x1234 one cycle later.
- Loads: rdata=0x80FF7F01.
  - LB off=3 -> 0xFFFFFF80.
  - LBU off=1 -> 0x0000007F.
  - LH off=2 -> 0xFFFF80FF.
  - LHU off=0 -> 0x00007F01.
  - LW off=2 -> RegWr=0, exc_adel pulse.
- Suppression:
  - mem_ovf=1 for a write to r8 -> RegWr=0, exc_ovf=1 for one cycle.
  - mem_rw=0 -> RegWr=0, no exception.
- Link: mem_link=1, mem_pc8=0x3008 -> Rw=31, Busw=0x3008.
- Stall/flush:
  - 3-cycle stall -> outputs held, a single exc pulse, prev_* unchanged.
  - Stall and flush together -> RegWr=0 next cycle.
- Forwarding: back-to-back writes r3=0xA then r4=0xB -> in cycle 2, fwd_rw=4/0xB and prev_rw=3/0xA.
- With WB_RETIRE_CNT_EN: 5 valid instructions (one overflow, one stall cycle) -> retire_cnt=4.
